// File: rtl/led_fade_pwm_pkg.sv
// Shared types and constants for the LED fade/PWM block.
package led_fade_pwm_pkg;

  localparam int unsigned LEVEL_W = 8;
  localparam int unsigned PRESC_W = 16;
  localparam logic [LEVEL_W-1:0] PWM_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } ch_state_e;

  // Level 255 is forced high so full brightness has no one-tick gap per period.
  function automatic logic pwm_drive(input logic [LEVEL_W-1:0] level,
                                     input logic [LEVEL_W-1:0] cnt);
    return (level == PWM_MAX) | (cnt < level);
  endfunction

endpackage

// File: rtl/led_fade_ch.sv
// One LED channel: OFF/UP/ON/DOWN fade FSM, level register and PWM compare.
// Ports: PCLK, PRESET (sync, active-high), boundary (last cycle of a PWM
// period), pwm_cnt, led_in, brightness (target), fade_en -> led_pwm_out,
// fade_busy.
module led_fade_ch
  import led_fade_pwm_pkg::*;
#(
  parameter int unsigned FADE_STEP = 4
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               boundary,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  input  logic               led_in,
  input  logic [LEVEL_W-1:0] brightness,
  input  logic               fade_en,
  output logic               led_pwm_out,
  output logic               fade_busy
);

  localparam logic [LEVEL_W:0]   STEP9 = (LEVEL_W+1)'(FADE_STEP);
  localparam logic [LEVEL_W-1:0] STEP8 = LEVEL_W'(FADE_STEP);

  ch_state_e          state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W:0]   up_sum;

  // Next state/level; inputs only matter in the boundary cycle.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    // 9-bit sum so a large step near 255 cannot wrap past the target.
    up_sum  = {1'b0, level_q} + STEP9;
    if (boundary) begin
      unique case (state_q)
        ST_OFF: begin
          if (led_in) begin
            if (fade_en) begin
              state_d = ST_UP;
            end else begin
              state_d = ST_ON;
              level_d = brightness;
            end
          end else begin
            level_d = '0;
          end
        end
        ST_UP: begin
          if (!led_in) begin
            state_d = ST_DOWN;
          end else if (!fade_en || (up_sum >= {1'b0, brightness})) begin
            state_d = ST_ON;
            level_d = brightness;
          end else begin
            level_d = up_sum[LEVEL_W-1:0];
          end
        end
        ST_ON: begin
          if (!led_in) begin
            if (fade_en) begin
              state_d = ST_DOWN;
            end else begin
              state_d = ST_OFF;
              level_d = '0;
            end
          end else begin
            level_d = brightness;
          end
        end
        ST_DOWN: begin
          if (led_in) begin
            state_d = ST_UP;
          end else if (!fade_en || (level_q <= STEP8)) begin
            state_d = ST_OFF;
            level_d = '0;
          end else begin
            level_d = level_q - STEP8;
          end
        end
        default: begin
          state_d = ST_OFF;
          level_d = '0;
        end
      endcase
    end
  end

  // State, level and registered pin outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_OFF;
      level_q     <= '0;
      led_pwm_out <= 1'b0;
      fade_busy   <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      led_pwm_out <= pwm_drive(level_q, pwm_cnt);
      // Decoded from the next state so busy moves together with the state.
      fade_busy   <= (state_d == ST_UP) || (state_d == ST_DOWN);
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// LED PWM driver with optional linear fade per channel.
// Ports: PCLK, PRESET (sync, active-high), led_in[NUM_CH], brightness
// [8*NUM_CH] (channel i in bits [8i+7:8i]), fade_en[NUM_CH] ->
// led_pwm_out[NUM_CH], fade_busy[NUM_CH], period_start (1-cycle pulse).
module led_fade_pwm
  import led_fade_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned PRESCALE  = 16,
  parameter int unsigned FADE_STEP = 4
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic [NUM_CH-1:0]          led_in,
  input  logic [LEVEL_W*NUM_CH-1:0]  brightness,
  input  logic [NUM_CH-1:0]          fade_en,
  output logic [NUM_CH-1:0]          led_pwm_out,
  output logic [NUM_CH-1:0]          fade_busy,
  output logic                       period_start
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] presc_cnt;
  logic [LEVEL_W-1:0] pwm_cnt;
  logic               tick_c;
  logic               boundary_c;

  assign tick_c     = (presc_cnt == PRESC_LAST);
  assign boundary_c = tick_c && (pwm_cnt == PWM_MAX);

  // Prescaler, PWM counter and period-start pulse.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      presc_cnt    <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      presc_cnt    <= tick_c ? '0 : presc_cnt + PRESC_W'(1);
      if (tick_c) begin
        pwm_cnt <= pwm_cnt + LEVEL_W'(1);
      end
      period_start <= boundary_c;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_fade_ch #(
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .PCLK        (PCLK),
      .PRESET      (PRESET),
      .boundary    (boundary_c),
      .pwm_cnt     (pwm_cnt),
      .led_in      (led_in[i]),
      .brightness  (brightness[LEVEL_W*i +: LEVEL_W]),
      .fade_en     (fade_en[i]),
      .led_pwm_out (led_pwm_out[i]),
      .fade_busy   (fade_busy[i])
    );
  end

endmodule
